// File: rtl/crypto1_pkg.sv
// Shared definitions for the Crypto-1 candidate extension stage:
// filter function constants, FSM state encoding and the 20-bit filter.
package crypto1_pkg;

   localparam logic [15:0] FA_NLF = 16'h9E98;
   localparam logic [15:0] FB_NLF = 16'hB48E;
   localparam logic [31:0] FC_NLF = 32'hEC57E80A;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EVAL  = 3'd2,
      EMIT  = 3'd3,
      BACK  = 3'd4
   } ext_state_t;

   function automatic logic [3:0] bitrev4(input logic [3:0] n);
      return {n[0], n[1], n[2], n[3]};
   endfunction

   // Nibble i feeds first-layer table t_i; t_0 lands in idx bit 4, t_4 in idx bit 0.
   function automatic logic filter20(input logic [19:0] x);
      logic [4:0] idx;
      logic [3:0] r;
      idx = '0;
      for (int i = 0; i < 5; i++) begin
         r = bitrev4(x[4*i +: 4]);
         idx[4-i] = (i == 2 || i == 4) ? FB_NLF[r] : FA_NLF[r];
      end
      return FC_NLF[idx];
   endfunction

endpackage

// File: rtl/crypto1_filter20.sv
// Combinational Crypto-1 filter over a 20-bit LFSR window.
module crypto1_filter20
   import crypto1_pkg::*;
(
   input  logic [19:0] x,
   output logic        y
);

   assign y = filter20(x);

endmodule

// File: rtl/crypto1_extend.sv
// Depth-first extension of 20-bit filter candidates by EXT LFSR bits,
// pruned against EXT keystream bits; survivors are streamed out.
//
// Handshakes: a transfer happens on a rising CLK edge where VALID and READY
// are both high. The sender holds VALID and its payload stable until that
// edge; READY may change freely. CAND_READY and OUT_VALID are decoded
// directly from the state register and never depend on the partner's signal.
module crypto1_extend
   import crypto1_pkg::*;
#(
   parameter int EXT = 8
)
(
   input  logic                CLK,
   input  logic                RESETn,
   input  logic                START,
   input  logic [EXT-1:0]      KS,
   input  logic                CAND_VALID,
   input  logic [19:0]         CAND,
   output logic                CAND_READY,
   input  logic                SRC_DONE,
   output logic                OUT_VALID,
   output logic [20+EXT-1:0]   OUT_STATE,
   input  logic                OUT_READY,
   output logic                BUSY,
   output logic                DONE,
   output logic [15:0]         SURV_CNT,
   output ext_state_t          DBG_STATE
);

   localparam int W  = 20 + EXT;
   localparam int LW = (EXT > 1) ? $clog2(EXT) : 1;

   ext_state_t     state, state_n;
   logic [W-1:0]   wr, wr_n;
   logic [LW-1:0]  lvl, lvl_n, lvl_inc, lvl_dec;
   logic [EXT-1:0] br, br_n;
   logic [EXT-1:0] ks, ks_n;
   logic           busy, busy_n;
   logic           done, done_n;
   logic [15:0]    cnt, cnt_n;
   logic [19:0]    n_eval;
   logic           filt;
   logic           pass;

   // Only filter instance: the window formed by shifting in the current branch bit.
   assign n_eval = {wr[18:0], br[lvl]};

   crypto1_filter20 u_filter (
      .x (n_eval),
      .y (filt)
   );

   assign pass    = (filt == ks[lvl]);
   assign lvl_inc = lvl + LW'(1);
   assign lvl_dec = lvl - LW'(1);

   // Next-state and datapath updates for the depth-first walk.
   always_comb begin
      state_n = state;
      wr_n    = wr;
      lvl_n   = lvl;
      br_n    = br;
      ks_n    = ks;
      busy_n  = busy;
      done_n  = done;
      cnt_n   = cnt;
      if (START) begin
         ks_n    = KS;
         done_n  = 1'b0;
         cnt_n   = '0;
         busy_n  = 1'b1;
         state_n = FETCH;
      end else begin
         case (state)
            IDLE: ;
            FETCH: begin
               if (CAND_VALID) begin
                  wr_n     = {{EXT{1'b0}}, CAND};
                  lvl_n    = '0;
                  br_n[0]  = 1'b0;
                  state_n  = EVAL;
               end else if (SRC_DONE) begin
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end
            end
            EVAL: begin
               if (pass) begin
                  wr_n = {wr[W-2:0], br[lvl]};
                  if (lvl == LW'(EXT-1)) begin
                     state_n = EMIT;
                  end else begin
                     lvl_n         = lvl_inc;
                     br_n[lvl_inc] = 1'b0;
                  end
               end else if (!br[lvl]) begin
                  br_n[lvl] = 1'b1;
               end else begin
                  state_n = BACK;
               end
            end
            EMIT: begin
               if (OUT_READY) begin
                  cnt_n = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                  wr_n  = wr >> 1;
                  if (!br[lvl]) begin
                     br_n[lvl] = 1'b1;
                     state_n   = EVAL;
                  end else begin
                     state_n = BACK;
                  end
               end
            end
            BACK: begin
               if (lvl == '0) begin
                  state_n = FETCH;
               end else begin
                  wr_n  = wr >> 1;
                  lvl_n = lvl_dec;
                  if (!br[lvl_dec]) begin
                     br_n[lvl_dec] = 1'b1;
                     state_n       = EVAL;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (!RESETn) state <= IDLE;
      else         state <= state_n;
   end

   // Datapath and status registers.
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         wr   <= '0;
         lvl  <= '0;
         br   <= '0;
         ks   <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
      end else begin
         wr   <= wr_n;
         lvl  <= lvl_n;
         br   <= br_n;
         ks   <= ks_n;
         busy <= busy_n;
         done <= done_n;
         cnt  <= cnt_n;
      end
   end

   assign CAND_READY = (state == FETCH);
   assign OUT_VALID  = (state == EMIT);
   assign OUT_STATE  = wr;
   assign BUSY       = busy;
   assign DONE       = done;
   assign SURV_CNT   = cnt;
   assign DBG_STATE  = state;

endmodule

// File: tb/tb_crypto1_extend.sv
// Directed bench for crypto1_extend: EXT=1 cycle-exact sequences, filter
// vectors, and an EXT=8 candidate stream checked against a DFS model.
module tb_crypto1_extend;
   import crypto1_pkg::*;

   logic CLK = 1'b0;
   logic RESETn = 1'b0;
   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // EXT=1 instance signals
   logic        start1 = 0, cv1 = 0, sd1 = 0, or1 = 1;
   logic [0:0]  ks1 = '0;
   logic [19:0] cand1 = '0;
   logic        cr1, ov1, busy1, done1;
   logic [20:0] os1;
   logic [15:0] cnt1;
   ext_state_t  st1;

   // EXT=8 instance signals
   logic        start8 = 0, cv8 = 0, sd8 = 0, or8 = 1;
   logic [7:0]  ks8 = '0;
   logic [19:0] cand8 = '0;
   logic        cr8, ov8, busy8, done8;
   logic [27:0] os8;
   logic [15:0] cnt8;
   ext_state_t  st8;

   logic [19:0] fx = '0;
   logic        fy;

   logic [27:0] exp_q[$];
   logic [19:0] cands [16];

   crypto1_extend #(.EXT(1)) u_dut1 (
      .CLK(CLK), .RESETn(RESETn), .START(start1), .KS(ks1),
      .CAND_VALID(cv1), .CAND(cand1), .CAND_READY(cr1), .SRC_DONE(sd1),
      .OUT_VALID(ov1), .OUT_STATE(os1), .OUT_READY(or1),
      .BUSY(busy1), .DONE(done1), .SURV_CNT(cnt1), .DBG_STATE(st1)
   );

   crypto1_extend #(.EXT(8)) u_dut8 (
      .CLK(CLK), .RESETn(RESETn), .START(start8), .KS(ks8),
      .CAND_VALID(cv8), .CAND(cand8), .CAND_READY(cr8), .SRC_DONE(sd8),
      .OUT_VALID(ov8), .OUT_STATE(os8), .OUT_READY(or8),
      .BUSY(busy8), .DONE(done8), .SURV_CNT(cnt8), .DBG_STATE(st8)
   );

   crypto1_filter20 u_filt (.x(fx), .y(fy));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Reference filter written from the function definition.
   function automatic logic ref_filter(input logic [19:0] x);
      logic [15:0] fa;
      logic [15:0] fb;
      logic [31:0] fc;
      logic [4:0]  idx;
      logic [3:0]  nib;
      logic [3:0]  r;
      fa = 16'h9E98;
      fb = 16'hB48E;
      fc = 32'hEC57E80A;
      idx = '0;
      for (int i = 0; i < 5; i++) begin
         nib = x[4*i +: 4];
         r = {nib[0], nib[1], nib[2], nib[3]};
         idx[4-i] = (i == 2 || i == 4) ? fb[r] : fa[r];
      end
      return fc[idx];
   endfunction

   // EXT=1, KS=0, CAND=0: both branches survive.
   task automatic run_a(input string tag);
      ks1 = 1'b0; or1 = 1'b1; start1 = 1'b1; cyc(); start1 = 1'b0;
      check({tag, "_ready"}, cr1, 1);
      check({tag, "_busy"}, busy1, 1);
      cand1 = 20'h00000; cv1 = 1'b1; cyc(); cv1 = 1'b0;
      check({tag, "_eval"}, 32'(st1), 32'(EVAL));
      cyc();
      check({tag, "_ov0"}, ov1, 1);
      check({tag, "_os0"}, os1, 32'h000000);
      cyc();
      check({tag, "_ov_gap"}, ov1, 0);
      cyc();
      check({tag, "_ov1"}, ov1, 1);
      check({tag, "_os1"}, os1, 32'h000001);
      cyc();
      check({tag, "_back"}, 32'(st1), 32'(BACK));
      check({tag, "_cnt"}, cnt1, 2);
      cyc();
      check({tag, "_ready_again"}, cr1, 1);
   endtask

   initial begin
      logic [19:0] fv [9];
      logic        fe [9];
      logic [27:0] s;
      logic [19:0] n;
      logic        ok;
      logic        b;
      int          total;

      fv = '{20'h00000, 20'h00001, 20'h0000C, 20'hC0000, 20'hCCCCC,
             20'h0C00C, 20'h000CC, 20'h00CC0, 20'h0C000};
      fe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset state
      RESETn = 1'b0;
      repeat (3) cyc();
      check("rst_ready", cr1, 0);
      check("rst_ov", ov1, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_cnt", cnt1, 0);
      check("rst_state", 32'(st8), 32'(IDLE));
      check("rst_ready8", cr8, 0);
      RESETn = 1'b1;
      cyc();

      // Filter vectors
      for (int i = 0; i < 9; i++) begin
         fx = fv[i];
         #1;
         check($sformatf("filter_%05h", fv[i]), fy, fe[i]);
      end

      // Two survivors, then source exhausted
      run_a("a");
      sd1 = 1'b1; cyc();
      check("a_done", done1, 1);
      check("a_busy_off", busy1, 0);
      check("a_idle", 32'(st1), 32'(IDLE));
      sd1 = 1'b0;

      // KS=1, CAND=0: both branches fail
      ks1 = 1'b1; start1 = 1'b1; cyc(); start1 = 1'b0;
      check("b_done_clr", done1, 0);
      cand1 = 20'h00000; cv1 = 1'b1; cyc(); cv1 = 1'b0;
      cyc();
      check("b_eval_br1", 32'(st1), 32'(EVAL));
      cyc();
      check("b_back", 32'(st1), 32'(BACK));
      cyc();
      check("b_fetch", cr1, 1);
      check("b_cnt", cnt1, 0);

      // Stall, held CAND_VALID, and SRC_DONE with the final candidate
      ks1 = 1'b1; start1 = 1'b1; cyc(); start1 = 1'b0;
      or1 = 1'b0; cand1 = 20'h00006; cv1 = 1'b1; sd1 = 1'b1; cyc();
      check("c_accept", 32'(st1), 32'(EVAL));
      check("c_not_done", done1, 0);
      cand1 = 20'h00999;
      cyc();
      check("c_ov", ov1, 1);
      check("c_os", os1, 32'h00000C);
      for (int i = 0; i < 50; i++) begin
         cyc();
         check("c_stall_ov", ov1, 1);
         check("c_stall_os", os1, 32'h00000C);
         check("c_stall_ready", cr1, 0);
      end
      cv1 = 1'b0; or1 = 1'b1; cyc();
      check("c_cnt1", cnt1, 1);
      check("c_eval2", 32'(st1), 32'(EVAL));
      cyc();
      check("c_ov2", ov1, 1);
      check("c_os2", os1, 32'h00000D);
      cyc();
      check("c_back", 32'(st1), 32'(BACK));
      check("c_cnt2", cnt1, 2);
      check("c_done_wait", done1, 0);
      cyc();
      check("c_fetch", 32'(st1), 32'(FETCH));
      check("c_done_wait2", done1, 0);
      cyc();
      check("c_done", done1, 1);
      check("c_busy", busy1, 0);
      sd1 = 1'b0;

      // Reset while a survivor is pending, then rerun
      ks1 = 1'b0; start1 = 1'b1; cyc(); start1 = 1'b0;
      or1 = 1'b0; cand1 = 20'h00000; cv1 = 1'b1; cyc(); cv1 = 1'b0;
      cyc();
      check("e_in_emit", ov1, 1);
      RESETn = 1'b0; cyc();
      check("e_rst_ov", ov1, 0);
      check("e_rst_os", os1, 0);
      check("e_rst_ready", cr1, 0);
      check("e_rst_busy", busy1, 0);
      check("e_rst_done", done1, 0);
      check("e_rst_cnt", cnt1, 0);
      check("e_rst_state", 32'(st1), 32'(IDLE));
      RESETn = 1'b1; or1 = 1'b1; cyc();
      run_a("e_rerun");

      // EXT=8 stream against the DFS model
      ks8 = 8'hA5;
      for (int i = 0; i < 16; i++) cands[i] = 20'h5A5A5 ^ (20'(i) * 20'h0B7D3);
      for (int c = 0; c < 16; c++) begin
         for (int e = 0; e < 256; e++) begin
            s = {8'h00, cands[c]};
            ok = 1'b1;
            for (int d = 0; d < 8; d++) begin
               b = e[7-d];
               n = {s[18:0], b};
               if (ref_filter(n) != ks8[d]) ok = 1'b0;
               s = {s[26:0], b};
            end
            if (ok) exp_q.push_back({cands[c], 8'(e)});
         end
      end
      total = exp_q.size();
      start8 = 1'b1; cyc(); start8 = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               int g;
               g = 0;
               cand8 = cands[i]; cv8 = 1'b1;
               do begin
                  @(negedge CLK);
                  g++;
               end while (!cr8 && g < 2000);
               if (!cr8) begin
                  check("d_drv_timeout", cr8, 1);
                  break;
               end
               @(posedge CLK);
               #1;
            end
            cv8 = 1'b0; sd8 = 1'b1;
         end
         begin
            int g;
            g = 0;
            while (!done8 && g < 40000) begin
               @(negedge CLK);
               g++;
               or8 = (g % 4 != 3);
               if (ov8 && or8) begin
                  if (exp_q.size() == 0) check("d_extra", os8, 32'hFFFFFFFF);
                  else check("d_surv", os8, exp_q.pop_front());
               end
            end
         end
      join
      check("d_done", done8, 1);
      check("d_busy", busy8, 0);
      check("d_missing", exp_q.size(), 0);
      check("d_cnt", cnt8, total);
      sd8 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
